// File: rtl/tensor_stage_buffer.sv
// rtl/tensor_stage_buffer.sv - operand banks A/B/W plus result FIFO X between tensor DMA and compute array
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   set, busy                  DMA target bank (0=A,1=B,2=X,3=W) and DMA busy
//   tensor_wen, mem_data_in    DMA word write into bank[set] (ignored for X)
//   tensor_ren                 DMA pop of X FIFO (only when set=2)
//   depth_in, width_in         DMA transfer dimensions, checked against fill count
//   mem_data_out/_valid        registered X pop result
//   x_push, x_data_in          compute-array push into X
//   rd_en, rd_bank, rd_idx     compute-array read of bank A/B/W
//   rd_data, rd_valid          registered read result
//   clear                      synchronous clear of pointers, counts and flags
//   bank_ready, x_count        per-bank ready (bit 2 = X non-empty), X occupancy
//   size_err, overflow, underflow  sticky error flags
module tensor_stage_buffer #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 16,
    parameter int ADDRW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           set,
    input  logic                 busy,
    input  logic                 tensor_wen,
    input  logic                 tensor_ren,
    input  logic [DATAWIDTH-1:0] mem_data_in,
    input  logic [DATAWIDTH-1:0] depth_in,
    input  logic [DATAWIDTH-1:0] width_in,
    output logic [DATAWIDTH-1:0] mem_data_out,
    output logic                 mem_data_valid,
    input  logic                 x_push,
    input  logic [DATAWIDTH-1:0] x_data_in,
    input  logic                 rd_en,
    input  logic [1:0]           rd_bank,
    input  logic [ADDRW-1:0]     rd_idx,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 clear,
    output logic [3:0]           bank_ready,
    output logic [ADDRW:0]       x_count,
    output logic                 size_err,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int PW    = ADDRW + 1;
    localparam int PRODW = 2 * DATAWIDTH;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // Bank 2 entries of mem_q / wr_ptr_q are never used; X lives in xmem_q.
    logic [DATAWIDTH-1:0] mem_q  [4][DEPTH];
    logic [DATAWIDTH-1:0] xmem_q [DEPTH];

    logic                 busy_q;
    logic [1:0]           xfer_set_q, xfer_set_d;
    logic [3:0][PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [3:0]           ready_q, ready_d;
    logic                 size_err_q, size_err_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic [ADDRW-1:0]     x_wr_ptr_q, x_wr_ptr_d, x_rd_ptr_q, x_rd_ptr_d;
    logic [PW-1:0]        x_count_q, x_count_d;
    logic [DATAWIDTH-1:0] mem_data_out_q, mem_data_out_d;
    logic                 mem_data_valid_q, mem_data_valid_d;
    logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    logic                 busy_rise, busy_fall;
    logic                 bank_we, x_we;
    logic [ADDRW-1:0]     bank_waddr;
    logic                 push_ok, pop_req, pop_ok, rd_hit;
    logic [PRODW-1:0]     xfer_size;

    assign xfer_size = PRODW'(depth_in) * PRODW'(width_in);

    always_comb begin
        busy_rise        = busy & ~busy_q;
        busy_fall        = ~busy & busy_q;
        xfer_set_d       = xfer_set_q;
        wr_ptr_d         = wr_ptr_q;
        ready_d          = ready_q;
        size_err_d       = size_err_q;
        overflow_d       = overflow_q;
        underflow_d      = underflow_q;
        bank_we          = 1'b0;
        bank_waddr       = '0;
        x_wr_ptr_d       = x_wr_ptr_q;
        x_rd_ptr_d       = x_rd_ptr_q;
        x_count_d        = x_count_q;
        mem_data_out_d   = mem_data_out_q;
        mem_data_valid_d = 1'b0;
        rd_data_d        = rd_data_q;
        rd_valid_d       = 1'b0;

        // End of a DMA transfer: bank becomes ready, fill count checked.
        if (busy_fall && xfer_set_q != 2'd2) begin
            ready_d[xfer_set_q] = 1'b1;
            if (PRODW'(wr_ptr_q[xfer_set_q]) != xfer_size) begin
                size_err_d = 1'b1;
            end
        end

        // Start of a DMA transfer restarts the fill of the target bank.
        if (busy_rise) begin
            xfer_set_d = set;
            if (set != 2'd2) begin
                wr_ptr_d[set] = '0;
                ready_d[set]  = 1'b0;
            end
        end

        // A word arriving on the rising-edge cycle lands at entry 0.
        if (tensor_wen && set != 2'd2) begin
            if (wr_ptr_d[set] < DEPTH_P) begin
                bank_we       = ~clear;
                bank_waddr    = wr_ptr_d[set][ADDRW-1:0];
                wr_ptr_d[set] = wr_ptr_d[set] + PW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end

        // X FIFO: push qualification uses the pre-pop count, so a push into
        // an empty FIFO alongside a pop still succeeds while the pop underflows.
        push_ok = x_push && (x_count_q < DEPTH_P);
        pop_req = tensor_ren && (set == 2'd2);
        pop_ok  = pop_req && (x_count_q != '0);
        x_we    = push_ok && ~clear;

        if (x_push && !push_ok) overflow_d  = 1'b1;
        if (pop_req && !pop_ok) underflow_d = 1'b1;

        if (push_ok) x_wr_ptr_d = x_wr_ptr_q + ADDRW'(1);
        if (pop_ok) begin
            x_rd_ptr_d       = x_rd_ptr_q + ADDRW'(1);
            mem_data_out_d   = xmem_q[x_rd_ptr_q];
            mem_data_valid_d = 1'b1;
        end
        x_count_d = x_count_q + PW'(push_ok) - PW'(pop_ok);

        // Registered read; same-cycle writes are not yet visible (read-before-write).
        rd_hit = rd_en && (rd_bank != 2'd2);
        if (rd_hit) begin
            rd_data_d  = mem_q[rd_bank][rd_idx];
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            busy_q           <= 1'b0;
            xfer_set_q       <= '0;
            wr_ptr_q         <= '0;
            ready_q          <= '0;
            size_err_q       <= 1'b0;
            overflow_q       <= 1'b0;
            underflow_q      <= 1'b0;
            x_wr_ptr_q       <= '0;
            x_rd_ptr_q       <= '0;
            x_count_q        <= '0;
            mem_data_out_q   <= '0;
            mem_data_valid_q <= 1'b0;
            rd_data_q        <= '0;
            rd_valid_q       <= 1'b0;
        end else begin
            busy_q           <= busy;
            xfer_set_q       <= xfer_set_d;
            wr_ptr_q         <= wr_ptr_d;
            ready_q          <= ready_d;
            size_err_q       <= size_err_d;
            overflow_q       <= overflow_d;
            underflow_q      <= underflow_d;
            x_wr_ptr_q       <= x_wr_ptr_d;
            x_rd_ptr_q       <= x_rd_ptr_d;
            x_count_q        <= x_count_d;
            mem_data_out_q   <= mem_data_out_d;
            mem_data_valid_q <= mem_data_valid_d;
            rd_data_q        <= rd_data_d;
            rd_valid_q       <= rd_valid_d;
        end
    end

    // Storage carries no reset; contents after reset/clear are don't-care.
    always_ff @(posedge clk) begin
        if (bank_we) mem_q[set][bank_waddr] <= mem_data_in;
        if (x_we)    xmem_q[x_wr_ptr_q]     <= x_data_in;
    end

    // ready_q[2] is never set, so OR-ing in the X non-empty bit is exact.
    assign bank_ready     = ready_q | {1'b0, (x_count_q != '0), 2'b00};
    assign x_count        = x_count_q;
    assign size_err       = size_err_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;
    assign mem_data_out   = mem_data_out_q;
    assign mem_data_valid = mem_data_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
endmodule

// File: tb/tb_tensor_stage_buffer.sv
// tb/tb_tensor_stage_buffer.sv - directed self-checking bench for tensor_stage_buffer
module tb_tensor_stage_buffer;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    set;
    logic          busy, tensor_wen, tensor_ren;
    logic [DW-1:0] mem_data_in, depth_in, width_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_data_valid;
    logic          x_push;
    logic [DW-1:0] x_data_in;
    logic          rd_en;
    logic [1:0]    rd_bank;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          clear;
    logic [3:0]    bank_ready;
    logic [AW:0]   x_count;
    logic          size_err, overflow, underflow;

    int n_cmp = 0;
    int n_bad = 0;

    tensor_stage_buffer #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .set(set), .busy(busy),
        .tensor_wen(tensor_wen), .tensor_ren(tensor_ren),
        .mem_data_in(mem_data_in), .depth_in(depth_in), .width_in(width_in),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
        .x_push(x_push), .x_data_in(x_data_in),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_idx(rd_idx),
        .rd_data(rd_data), .rd_valid(rd_valid), .clear(clear),
        .bank_ready(bank_ready), .x_count(x_count),
        .size_err(size_err), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; set = 2'd0; busy = 1'b0; tensor_wen = 1'b0; tensor_ren = 1'b0;
        mem_data_in = '0; depth_in = '0; width_in = '0; x_push = 1'b0; x_data_in = '0;
        rd_en = 1'b0; rd_bank = 2'd0; rd_idx = '0; clear = 1'b0;
        step(); step();
        check("rst_bank_ready", bank_ready, 4'b0000);
        check("rst_x_count", x_count, 0);
        check("rst_flags", {size_err, overflow, underflow, mem_data_valid, rd_valid}, 0);
        rst = 1'b0;
        step();

        // 1: fill A with 1..6, 2x3 transfer
        depth_in = 8'd2; width_in = 8'd3; set = 2'd0; busy = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            tensor_wen = 1'b1; mem_data_in = DW'(i + 1);
            step();
        end
        tensor_wen = 1'b0;
        step();
        busy = 1'b0;
        step();
        check("a_bank_ready", bank_ready, 4'b0001);
        check("a_size_err", size_err, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rd_en = 1'b1; rd_bank = 2'd0; rd_idx = AW'(i);
            step();
            check("a_rd_valid", rd_valid, 1'b1);
            check("a_rd_data", rd_data, i + 1);
        end
        rd_en = 1'b0; rd_bank = 2'd2;
        step();
        check("a_rd_valid_idle", rd_valid, 1'b0);
        rd_en = 1'b1;
        step();
        check("rd_bank2_invalid", rd_valid, 1'b0);
        rd_en = 1'b0;

        // 2: size mismatch on B, 3 words for a 2x2 transfer
        depth_in = 8'd2; width_in = 8'd2; set = 2'd1; busy = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            tensor_wen = 1'b1; mem_data_in = DW'(8'h10 + i);
            step();
        end
        tensor_wen = 1'b0; busy = 1'b0;
        step();
        check("b_bank_ready", bank_ready, 4'b0011);
        check("b_size_err", size_err, 1'b1);
        do_clear();
        check("clr_bank_ready", bank_ready, 4'b0000);
        check("clr_size_err", size_err, 1'b0);

        // 3: X FIFO push 4, pop 4, then underflow
        for (int i = 0; i < 4; i++) begin
            x_push = 1'b1; x_data_in = DW'(8'hA0 + i);
            step();
        end
        x_push = 1'b0;
        check("x_count4", x_count, 4);
        check("x_ready", bank_ready, 4'b0100);
        set = 2'd2; tensor_ren = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("x_pop_valid", mem_data_valid, 1'b1);
            check("x_pop_data", mem_data_out, 8'hA0 + i);
        end
        step();
        tensor_ren = 1'b0;
        check("x_under_valid", mem_data_valid, 1'b0);
        check("x_under_flag", underflow, 1'b1);
        check("x_under_count", x_count, 0);
        check("x_under_hold", mem_data_out, 8'hA3);
        do_clear();

        // 4: 17 writes to W, then 17 X pushes
        set = 2'd3; busy = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            tensor_wen = 1'b1; mem_data_in = DW'(8'h30 + i);
            step();
        end
        tensor_wen = 1'b0;
        check("w_overflow", overflow, 1'b1);
        check("w_wr_ptr", dut.wr_ptr_q[3], 16);
        busy = 1'b0;
        step();
        check("w_size_err", size_err, 1'b1);
        rd_en = 1'b1; rd_bank = 2'd3; rd_idx = 4'd15;
        step();
        check("w_entry15", rd_data, 8'h3F);
        rd_idx = 4'd0;
        step();
        check("w_entry0", rd_data, 8'h30);
        rd_en = 1'b0;
        do_clear();
        check("clr_overflow", overflow, 1'b0);
        for (int i = 0; i < 17; i++) begin
            x_push = 1'b1; x_data_in = DW'(8'h50 + i);
            step();
        end
        x_push = 1'b0;
        check("x_full_count", x_count, 16);
        check("x_full_overflow", overflow, 1'b1);
        do_clear();

        // 5: simultaneous push/pop
        for (int i = 0; i < 3; i++) begin
            x_push = 1'b1; x_data_in = DW'(8'h61 + i);
            step();
        end
        set = 2'd2; tensor_ren = 1'b1; x_push = 1'b1; x_data_in = 8'h64;
        step();
        x_push = 1'b0;
        check("pp_count", x_count, 3);
        check("pp_data", mem_data_out, 8'h61);
        for (int i = 0; i < 3; i++) begin
            step();
            check("pp_order", mem_data_out, 8'h62 + i);
        end
        check("pp_empty", x_count, 0);
        x_push = 1'b1; x_data_in = 8'h70;
        step();
        tensor_ren = 1'b0; x_push = 1'b0;
        check("pp0_count", x_count, 1);
        check("pp0_underflow", underflow, 1'b1);
        check("pp0_valid", mem_data_valid, 1'b0);
        do_clear();

        // 6: async reset mid-fill, then clear with a write
        set = 2'd0; busy = 1'b1; x_push = 1'b1; x_data_in = 8'h77;
        step();
        x_push = 1'b0;
        tensor_wen = 1'b1; mem_data_in = 8'h11;
        step();
        tensor_wen = 1'b0;
        check("pre_rst_count", x_count, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_x_count", x_count, 0);
        check("arst_bank_ready", bank_ready, 4'b0000);
        check("arst_outs", {size_err, overflow, underflow, mem_data_valid, rd_valid, rd_data, mem_data_out}, 0);
        check("arst_wr_ptr", dut.wr_ptr_q[0], 0);
        step();
        rst = 1'b0;
        tensor_wen = 1'b1; mem_data_in = 8'h99; clear = 1'b1;
        step();
        clear = 1'b0; tensor_wen = 1'b0; busy = 1'b0;
        check("clr_wen_ptr", dut.wr_ptr_q[0], 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
